adc_scan_sequencer: RTL and testbench

- Sequences the 8:1 analog input multiplexer (74HC4051-style, active-low enable, 3 select lines) and the 12-bit serial ADC reader.
- For each enabled channel it selects the mux input and waits a settling time. It then triggers N conversions and averages them.
- Each averaged result is emitted tagged with its channel number. Sits between the front-end mux/ADC reader and the measurement/display logic.

---
 rtl/adc_scan_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for an 8:1 analog mux feeding a serial ADC reader: settles each
// enabled channel, averages 2^avg_log2 conversions and emits channel-tagged results.
module adc_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 25,
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        start,
  input  logic [7:0]  chan_mask,
  input  logic [1:0]  avg_log2,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [11:0] adc_sample,
  output logic        mux_en_n,
  output logic [2:0]  mux_sel,
  output logic        busy,
  output logic        res_valid,
  output logic [2:0]  res_chan,
  output logic [11:0] res_data,
  output logic        res_error,
  output logic        scan_done
);

  localparam int unsigned CHANS     = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned DATA_W    = 12;
  localparam int unsigned ACC_W     = 15;
  localparam int unsigned SCNT_W    = 4;
  localparam int unsigned SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONVERT,
    WAIT_DONE,
    EMIT,
    FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [CHANS-1:0]      mask_q, mask_d;
  logic [1:0]            avg_q, avg_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [TIMEOUT_W-1:0]  tout_cnt_q, tout_cnt_d;
  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  logic [ACC_W-1:0]      acc_q, acc_d;

  logic                  adc_start_d, mux_en_n_d, busy_d, res_valid_d, res_error_d, scan_done_d;
  logic [SEL_W-1:0]      mux_sel_d, res_chan_d;
  logic [DATA_W-1:0]     res_data_d;

  logic [ACC_W-1:0]      acc_sum;
  logic [SCNT_W-1:0]     scnt_inc, scnt_tgt;
  logic [SEL_W:0]        lowest_new, next_higher;

  // {found, index} of the lowest set bit
  function automatic logic [SEL_W:0] first_set(input logic [CHANS-1:0] m);
    first_set = '0;
    for (int i = int'(CHANS) - 1; i >= 0; i--) begin
      if (m[i]) first_set = {1'b1, SEL_W'(i)};
    end
  endfunction

  function automatic logic [CHANS-1:0] above(input logic [SEL_W-1:0] c);
    above = '0;
    for (int i = 0; i < int'(CHANS); i++) begin
      above[i] = (i > int'(c));
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      avg_q        <= '0;
      settle_cnt_q <= '0;
      tout_cnt_q   <= '0;
      scnt_q       <= '0;
      acc_q        <= '0;
      adc_start    <= 1'b0;
      mux_en_n     <= 1'b1;
      mux_sel      <= '0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_chan     <= '0;
      res_data     <= '0;
      res_error    <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      avg_q        <= avg_d;
      settle_cnt_q <= settle_cnt_d;
      tout_cnt_q   <= tout_cnt_d;
      scnt_q       <= scnt_d;
      acc_q        <= acc_d;
      adc_start    <= adc_start_d;
      mux_en_n     <= mux_en_n_d;
      mux_sel      <= mux_sel_d;
      busy         <= busy_d;
      res_valid    <= res_valid_d;
      res_chan     <= res_chan_d;
      res_data     <= res_data_d;
      res_error    <= res_error_d;
      scan_done    <= scan_done_d;
    end
  end

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    avg_d        = avg_q;
    settle_cnt_d = settle_cnt_q;
    tout_cnt_d   = tout_cnt_q;
    scnt_d       = scnt_q;
    acc_d        = acc_q;
    adc_start_d  = 1'b0;
    mux_en_n_d   = mux_en_n;
    mux_sel_d    = mux_sel;
    busy_d       = busy;
    res_valid_d  = 1'b0;
    res_chan_d   = res_chan;
    res_data_d   = res_data;
    res_error_d  = res_error;
    scan_done_d  = 1'b0;
    acc_sum      = acc_q + ACC_W'(adc_sample);
    scnt_inc     = scnt_q + SCNT_W'(1);
    scnt_tgt     = SCNT_W'(1) << avg_q;
    lowest_new   = first_set(chan_mask);
    next_higher  = first_set(mask_q & above(mux_sel));

    case (state_q)
      IDLE: begin
        if ((start || run) && lowest_new[SEL_W]) begin
          mask_d       = chan_mask;
          avg_d        = avg_log2;
          mux_sel_d    = lowest_new[SEL_W-1:0];
          mux_en_n_d   = 1'b0;
          busy_d       = 1'b1;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          adc_start_d = 1'b1;
          state_d     = CONVERT;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end
      CONVERT: begin
        tout_cnt_d = '0;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A sample arriving on the expiring cycle takes priority over the timeout
        if (adc_done) begin
          acc_d  = acc_sum;
          scnt_d = scnt_inc;
          if (scnt_inc == scnt_tgt) begin
            res_valid_d = 1'b1;
            res_chan_d  = mux_sel;
            res_data_d  = DATA_W'(acc_sum >> avg_q);
            res_error_d = 1'b0;
            state_d     = EMIT;
          end else begin
            adc_start_d = 1'b1;
            state_d     = CONVERT;
          end
        end else if (tout_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          res_valid_d = 1'b1;
          res_chan_d  = mux_sel;
          res_data_d  = '0;
          res_error_d = 1'b1;
          state_d     = EMIT;
        end else begin
          tout_cnt_d = tout_cnt_q + TIMEOUT_W'(1);
        end
      end
      EMIT: begin
        acc_d  = '0;
        scnt_d = '0;
        if (next_higher[SEL_W]) begin
          mux_sel_d    = next_higher[SEL_W-1:0];
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end else begin
          scan_done_d = 1'b1;
          state_d     = FINISH;
        end
      end
      FINISH: begin
        if (run && lowest_new[SEL_W]) begin
          mask_d       = chan_mask;
          avg_d        = avg_log2;
          mux_sel_d    = lowest_new[SEL_W-1:0];
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end else begin
          mux_en_n_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: single/averaged scans, timeout, continuous mode,
// reset mid-conversion and ignored start/adc_done cases.
module tb_adc_scan_sequencer;

  localparam int S  = 25;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        start;
  logic [7:0]  chan_mask;
  logic [1:0]  avg_log2;
  logic        adc_start;
  logic        adc_done;
  logic [11:0] adc_sample;
  logic        mux_en_n;
  logic [2:0]  mux_sel;
  logic        busy;
  logic        res_valid;
  logic [2:0]  res_chan;
  logic [11:0] res_data;
  logic        res_error;
  logic        scan_done;

  int errors = 0;
  int checks = 0;
  int n_start = 0;
  int n_valid = 0;
  int n_done = 0;
  int gap = 0;
  int base_s, base_v, base_d, n;

  localparam logic [31:0] RST_OUTS = 32'({1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 12'd0, 1'b0, 1'b0});
  int ch_list [3] = '{2, 5, 7};

  adc_scan_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .start      (start),
    .chan_mask  (chan_mask),
    .avg_log2   (avg_log2),
    .adc_start  (adc_start),
    .adc_done   (adc_done),
    .adc_sample (adc_sample),
    .mux_en_n   (mux_en_n),
    .mux_sel    (mux_sel),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_chan   (res_chan),
    .res_data   (res_data),
    .res_error  (res_error),
    .scan_done  (scan_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({adc_start, mux_en_n, mux_sel, busy, res_valid, res_chan, res_data, res_error, scan_done});
  endfunction

  function automatic logic [31:0] res_tuple();
    return 32'({res_valid, res_error, res_chan, res_data});
  endfunction

  // One clock; outputs sampled on the falling edge
  task automatic tick();
    @(negedge clk);
    if (adc_start) n_start++;
    if (res_valid) n_valid++;
    if (scan_done) n_done++;
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (adc_start !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    gap = k;
    check(tag, 32'(adc_start), 32'd1);
  endtask

  // Answer the pending conversion d cycles into WAIT_DONE
  task automatic respond(input int d, input logic [11:0] s);
    repeat (d) tick();
    adc_done   = 1'b1;
    adc_sample = s;
    tick();
    adc_done   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; start = 1'b0; chan_mask = '0; avg_log2 = '0;
    adc_done = 1'b0; adc_sample = '0;
    tick(); tick();
    check("reset_outs", outs(), RST_OUTS);
    reset = 1'b1;
    tick();

    // Single channel, no averaging
    chan_mask = 8'h01; avg_log2 = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy_en", 32'({busy, mux_en_n, mux_sel}), 32'({1'b1, 1'b0, 3'd0}));
    wait_start("t1_start");
    check("t1_gap", 32'(gap), 32'(S));
    respond(10, 12'hABC);
    check("t1_res", res_tuple(), 32'({1'b1, 1'b0, 3'd0, 12'hABC}));
    tick();
    check("t1_scan_done", 32'({scan_done, res_valid}), 32'({1'b1, 1'b0}));
    tick();
    check("t1_idle", 32'({busy, mux_en_n, scan_done, res_data}), 32'({1'b0, 1'b1, 1'b0, 12'hABC}));

    // Averaging over channels 2, 5, 7
    chan_mask = 8'b1010_0100; avg_log2 = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      base_s = n_start;
      for (int k = 0; k < 4; k++) begin
        wait_start("t2_start");
        check("t2_gap", 32'(gap), 32'(k != 0 ? 0 : (c == 0 ? S : S + 1)));
        check("t2_sel", 32'(mux_sel), 32'(ch_list[c]));
        respond(3, (c == 0) ? 12'(100 + k) : 12'hFFF);
      end
      check("t2_nstart", 32'(n_start - base_s), 32'd4);
      check("t2_res", res_tuple(),
            32'({1'b1, 1'b0, 3'(ch_list[c]), (c == 0) ? 12'd101 : 12'd4095}));
    end
    tick();
    check("t2_scan_done", 32'(scan_done), 32'd1);
    tick();
    check("t2_idle", 32'({busy, mux_en_n}), 32'({1'b0, 1'b1}));

    // Timeout on channel 3
    chan_mask = 8'h08; avg_log2 = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_start("t3_start");
    check("t3_sel", 32'(mux_sel), 32'd3);
    n = 0;
    do begin
      tick();
      n++;
    end while (res_valid !== 1'b1 && n < 300);
    check("t3_latency", 32'(n), 32'(TO + 1));
    check("t3_res", res_tuple(), 32'({1'b1, 1'b1, 3'd3, 12'd0}));
    tick();
    check("t3_scan_done", 32'(scan_done), 32'd1);
    tick();
    check("t3_idle", 32'({busy, mux_en_n}), 32'({1'b0, 1'b1}));

    // Sample arriving on the timeout cycle wins; error clears on a later scan
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_start("t3b_start");
    respond(TO, 12'h5A5);
    check("t3b_res", res_tuple(), 32'({1'b1, 1'b0, 3'd3, 12'h5A5}));
    tick(); tick();

    // Continuous mode; mask change only takes effect at the next scan
    run = 1'b1; chan_mask = 8'h03; avg_log2 = 2'd0;
    tick();
    chan_mask = 8'h80;
    wait_start("t4_start0");
    check("t4_sel0", 32'(mux_sel), 32'd0);
    respond(2, 12'h010);
    check("t4_res0", res_tuple(), 32'({1'b1, 1'b0, 3'd0, 12'h010}));
    wait_start("t4_start1");
    check("t4_gap1", 32'(gap), 32'(S + 1));
    check("t4_sel1", 32'(mux_sel), 32'd1);
    respond(2, 12'h011);
    check("t4_res1", res_tuple(), 32'({1'b1, 1'b0, 3'd1, 12'h011}));
    tick();
    check("t4_done1", 32'({scan_done, busy}), 32'({1'b1, 1'b1}));
    wait_start("t4_start7");
    check("t4_gap7", 32'(gap), 32'(S + 1));
    check("t4_sel7", 32'(mux_sel), 32'd7);
    run = 1'b0;
    respond(2, 12'h777);
    check("t4_res7", res_tuple(), 32'({1'b1, 1'b0, 3'd7, 12'h777}));
    tick();
    check("t4_done2", 32'(scan_done), 32'd1);
    tick();
    check("t4_idle", 32'({busy, mux_en_n}), 32'({1'b0, 1'b1}));
    base_s = n_start;
    repeat (40) tick();
    check("t4_no_rescan", 32'(n_start - base_s), 32'd0);

    // Reset during WAIT_DONE, then a stale adc_done
    chan_mask = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    wait_start("t5_start");
    tick(); tick();
    reset = 1'b0;
    tick();
    check("t5_reset_outs", outs(), RST_OUTS);
    base_v = n_valid; base_s = n_start;
    reset = 1'b1; adc_done = 1'b1; adc_sample = 12'hFFF;
    tick();
    adc_done = 1'b0;
    repeat (30) tick();
    check("t5_no_valid", 32'(n_valid - base_v), 32'd0);
    check("t5_no_start", 32'(n_start - base_s), 32'd0);
    check("t5_outs", outs(), RST_OUTS);

    // Empty mask is never started
    chan_mask = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_mask0_busy", 32'(busy), 32'd0);
    base_s = n_start;
    repeat (30) tick();
    check("t6_mask0_nstart", 32'(n_start - base_s), 32'd0);

    // start while busy and adc_done during SETTLE are both ignored
    chan_mask = 8'h02; avg_log2 = 2'd0; start = 1'b1;
    base_s = n_start; base_d = n_done;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; adc_done = 1'b1; adc_sample = 12'hFFF;
    tick();
    start = 1'b0; adc_done = 1'b0;
    wait_start("t6_start");
    check("t6_sel", 32'(mux_sel), 32'd1);
    respond(1, 12'h004);
    check("t6_res", res_tuple(), 32'({1'b1, 1'b0, 3'd1, 12'h004}));
    repeat (60) tick();
    check("t6_one_start", 32'(n_start - base_s), 32'd1);
    check("t6_one_scan", 32'(n_done - base_d), 32'd1);
    check("t6_idle", 32'({busy, mux_en_n}), 32'({1'b0, 1'b1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
